spi_xfer_arb: RTL

Round-robin transfer controller that shares one `spi_shift` engine among `NREQ` requesters. It loads each winner's character and shift configuration, frames the transfer with a per-requester active-low slave select (with setup/hold guard time), and pulses `go`. On completion it returns the received character with a one-cycle acknowledge. It sits between the requester-side logic and the shift engine; SCLK edge generation (`pos_edge`/`neg_edge`) remains external.

---
 rtl/spi_arb_pkg.sv | 28 ++
 rtl/spi_rr_pick.sv | 26 ++
 rtl/spi_xfer_arb.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared state encoding and shift-engine load constants for the SPI transfer arbiter.
package spi_arb_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_SETUP   = 3'd2;
   localparam logic [2:0] ST_GO      = 3'd3;
   localparam logic [2:0] ST_WAITTIP = 3'd4;
   localparam logic [2:0] ST_BUSY    = 3'd5;
   localparam logic [2:0] ST_HOLD    = 3'd6;
   localparam logic [2:0] ST_DONE    = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_LOAD    = ST_LOAD,
      S_SETUP   = ST_SETUP,
      S_GO      = ST_GO,
      S_WAITTIP = ST_WAITTIP,
      S_BUSY    = ST_BUSY,
      S_HOLD    = ST_HOLD,
      S_DONE    = ST_DONE
   } arb_state_t;

   // Loads only the first 32-bit word of the engine, all byte lanes enabled.
   localparam logic [3:0] LATCH_W0 = 4'b0001;
   localparam logic [3:0] BSEL_ALL = 4'hF;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module spi_rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   idx,
   output logic            valid
);

   always_comb begin
      int cand;
      idx   = '0;
      valid = 1'b0;
      cand  = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(ptr) + k) % NREQ;
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = PW'(cand);
         end
      end
   end

endmodule

// File: rtl/spi_xfer_arb.sv
// Round-robin transfer controller sharing one spi_shift engine among NREQ requesters,
// framing each transfer with a guarded active-low slave select.
module spi_xfer_arb
   import spi_arb_pkg::*;
#(
   parameter int NREQ          = 4,
   parameter int CHAR_LEN_BITS = 5,
   parameter int GUARD         = 2,
   parameter int TO_CYC        = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NREQ-1:0]               req,
   input  logic [NREQ*32-1:0]            req_data,
   input  logic [NREQ*CHAR_LEN_BITS-1:0] req_len,
   input  logic [NREQ-1:0]               req_lsb,
   input  logic [NREQ-1:0]               req_txneg,
   input  logic [NREQ-1:0]               req_rxneg,
   output logic [NREQ-1:0]               gnt,
   output logic                          ack,
   output logic                          err,
   output logic [31:0]                   rdata,
   output logic [NREQ-1:0]               ss_n,
   output logic [3:0]                    sh_latch,
   output logic [3:0]                    sh_byte_sel,
   output logic [31:0]                   sh_p_in,
   output logic [CHAR_LEN_BITS-1:0]      sh_len,
   output logic                          sh_lsb,
   output logic                          sh_tx_negedge,
   output logic                          sh_rx_negedge,
   output logic                          sh_go,
   input  logic                          sh_tip,
   input  logic [31:0]                   sh_p_out,
   output logic [2:0]                    state_dbg
);

   localparam int PW      = $clog2(NREQ);
   localparam int CNT_MAX = (GUARD > TO_CYC) ? GUARD : TO_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
   localparam logic [CW-1:0] TO_LAST    = CW'(TO_CYC - 1);

   arb_state_t                state, state_nxt;
   logic [CW-1:0]             cnt, cnt_nxt;
   logic [PW-1:0]             idx, ptr, pick_idx;
   logic                      pick_valid, err_r, err_set, tip_q;
   logic [NREQ-1:0]           pick_oh;
   logic [31:0]               pick_data;
   logic [CHAR_LEN_BITS-1:0]  pick_len;
   logic                      pick_lsb, pick_txneg, pick_rxneg;

   assign state_dbg = state;

   spi_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_comb begin
      pick_oh    = '0;
      pick_data  = '0;
      pick_len   = '0;
      pick_lsb   = 1'b0;
      pick_txneg = 1'b0;
      pick_rxneg = 1'b0;
      pick_oh[pick_idx] = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == PW'(i)) begin
            pick_data  = req_data[i*32 +: 32];
            pick_len   = req_len[i*CHAR_LEN_BITS +: CHAR_LEN_BITS];
            pick_lsb   = req_lsb[i];
            pick_txneg = req_txneg[i];
            pick_rxneg = req_rxneg[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // tip is taken through one flop, so detection of its edges costs one cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_set   = 1'b0;
      case (state)
         S_IDLE:    if (pick_valid) state_nxt = S_LOAD;
         S_LOAD: begin
            cnt_nxt   = '0;
            state_nxt = S_SETUP;
         end
         S_SETUP: begin
            if (cnt == GUARD_LAST) state_nxt = S_GO;
            else                   cnt_nxt   = cnt + CW'(1);
         end
         S_GO: begin
            cnt_nxt   = '0;
            state_nxt = S_WAITTIP;
         end
         S_WAITTIP: begin
            if (tip_q) begin
               state_nxt = S_BUSY;
            end else if (cnt == TO_LAST) begin
               err_set   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_HOLD;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_BUSY: begin
            if (!tip_q) begin
               cnt_nxt   = '0;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt == GUARD_LAST) state_nxt = S_DONE;
            else                   cnt_nxt   = cnt + CW'(1);
         end
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Outputs are flops keyed on the next state so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tip_q         <= 1'b0;
         idx           <= '0;
         ptr           <= '0;
         err_r         <= 1'b0;
         gnt           <= '0;
         ack           <= 1'b0;
         err           <= 1'b0;
         rdata         <= '0;
         ss_n          <= '1;
         sh_latch      <= '0;
         sh_byte_sel   <= '0;
         sh_p_in       <= '0;
         sh_len        <= '0;
         sh_lsb        <= 1'b0;
         sh_tx_negedge <= 1'b0;
         sh_rx_negedge <= 1'b0;
         sh_go         <= 1'b0;
      end else begin
         tip_q       <= sh_tip;
         sh_go       <= (state_nxt == S_GO);
         sh_latch    <= (state_nxt == S_LOAD) ? LATCH_W0 : 4'b0000;
         sh_byte_sel <= (state_nxt == S_LOAD) ? BSEL_ALL : 4'b0000;
         ack         <= (state_nxt == S_DONE);
         err         <= (state_nxt == S_DONE) && err_r;
         if (state == S_IDLE && pick_valid) begin
            idx           <= pick_idx;
            gnt           <= pick_oh;
            ss_n          <= ~pick_oh;
            sh_p_in       <= pick_data;
            sh_len        <= pick_len;
            sh_lsb        <= pick_lsb;
            sh_tx_negedge <= pick_txneg;
            sh_rx_negedge <= pick_rxneg;
            err_r         <= 1'b0;
         end
         if (err_set) err_r <= 1'b1;
         if (state == S_BUSY && !tip_q) rdata <= sh_p_out;
         if (state == S_HOLD && state_nxt == S_DONE) ss_n <= '1;
         if (state == S_DONE) begin
            gnt <= '0;
            ptr <= (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
         end
      end
   end

endmodule
